// File: rtl/prbs16_checker.sv
// Serial PRBS16 checker (XNOR generator, taps 16,15,13,4): fills a 16-bit history,
// hunts for LOCK_CNT consecutive correct predictions, then counts errors against a free-running local copy.
module prbs16_checker #(
  parameter int LOCK_CNT  = 32,
  parameter int WIN_LEN   = 64,
  parameter int LOSS_ERRS = 8,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic             din,
  input  logic             clr,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count,
  output logic             lock_lost,
  output logic [1:0]       state
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int EW = $clog2(LOSS_ERRS + 1);

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_HUNT   = 2'd1,
    S_LOCKED = 2'd2
  } state_e;

  function automatic logic predict(input logic [15:0] v);
    return ~(v[15] ^ v[14] ^ v[12] ^ v[3]);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_e           state_q, state_d;
  logic [15:0]      h_q, h_d;
  logic [15:0]      g_q, g_d;
  logic [3:0]       fill_q, fill_d;
  logic [MW-1:0]    match_q, match_d;
  logic [WW-1:0]    win_cnt_q, win_cnt_d;
  logic [EW-1:0]    win_err_q, win_err_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [CNT_W-1:0] bit_count_q, bit_count_d;
  logic             lock_lost_q, lock_lost_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;

  logic             miss;
  logic             loss;
  logic [EW-1:0]    win_err_n;

  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    g_d         = g_q;
    fill_d      = fill_q;
    match_d     = match_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    err_count_d = err_count_q;
    bit_count_d = bit_count_q;
    lock_lost_d = lock_lost_q;
    err_d       = 1'b0;
    miss        = 1'b0;
    loss        = 1'b0;
    win_err_n   = win_err_q;

    if (din_valid) begin
      case (state_q)
        S_FILL: begin
          h_d    = {h_q[14:0], din};
          fill_d = fill_q + 4'd1;
          if (fill_q == 4'd15) begin
            state_d = S_HUNT;
            match_d = '0;
          end
        end
        S_HUNT: begin
          h_d = {h_q[14:0], din};
          // All-ones history is the XNOR lock-up state and never counts as a match.
          if ((din == predict(h_q)) && (h_q != 16'hFFFF)) begin
            if (match_q == MW'(LOCK_CNT - 1)) begin
              state_d   = S_LOCKED;
              g_d       = h_d;
              match_d   = '0;
              win_cnt_d = '0;
              win_err_d = '0;
            end else begin
              match_d = match_q + MW'(1);
            end
          end else begin
            match_d = '0;
          end
        end
        S_LOCKED: begin
          g_d         = {g_q[14:0], predict(g_q)};
          // History tracks the clean sequence so a relock hunt starts from error-free bits.
          h_d         = g_d;
          miss        = (din != predict(g_q));
          bit_count_d = sat_inc(bit_count_q);
          if (miss) begin
            err_d       = 1'b1;
            err_count_d = sat_inc(err_count_q);
          end
          win_err_n = win_err_q + EW'(miss);
          if (win_err_n == EW'(LOSS_ERRS)) begin
            loss        = 1'b1;
            state_d     = S_HUNT;
            match_d     = '0;
            lock_lost_d = 1'b1;
          end
          if (win_cnt_q == WW'(WIN_LEN - 1)) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + WW'(1);
            win_err_d = win_err_n;
          end
        end
        default: state_d = S_FILL;
      endcase
    end

    if (clr) begin
      err_count_d = '0;
      bit_count_d = '0;
      lock_lost_d = loss;
    end

    locked_d = (state_d == S_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FILL;
      h_q         <= '0;
      g_q         <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      err_count_q <= '0;
      bit_count_q <= '0;
      lock_lost_q <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      g_q         <= g_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      err_count_q <= err_count_d;
      bit_count_q <= bit_count_d;
      lock_lost_q <= lock_lost_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
    end
  end

  assign locked    = locked_q;
  assign err       = err_q;
  assign err_count = err_count_q;
  assign bit_count = bit_count_q;
  assign lock_lost = lock_lost_q;
  assign state     = state_q;

endmodule

// File: tb/tb_prbs16_checker.sv
// Directed bench for prbs16_checker: default instance plus a CNT_W=4 instance sharing the same stimulus.
module tb_prbs16_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din_valid = 1'b0;
  logic        din = 1'b0;
  logic        clr = 1'b0;

  logic        locked, err, lock_lost;
  logic [31:0] err_count, bit_count;
  logic [1:0]  state;

  logic        locked4, err4, lock_lost4;
  logic [3:0]  err_count4, bit_count4;
  logic [1:0]  state4;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          err_seen = 0;
  int          lock_seen = 0;
  logic [15:0] gen_s = 16'hACE1;

  always #5 clk = ~clk;

  prbs16_checker dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .clr(clr),
    .locked(locked), .err(err), .err_count(err_count), .bit_count(bit_count),
    .lock_lost(lock_lost), .state(state)
  );

  prbs16_checker #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .clr(clr),
    .locked(locked4), .err(err4), .err_count(err_count4), .bit_count(bit_count4),
    .lock_lost(lock_lost4), .state(state4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference XNOR generator: new bit = ~(s15^s14^s12^s3), shifted in at bit 0.
  task automatic gen_next(output logic b);
    b = ~(gen_s[15] ^ gen_s[14] ^ gen_s[12] ^ gen_s[3]);
    gen_s = {gen_s[14:0], b};
  endtask

  task automatic send(input logic b, input logic v, input logic c);
    din = b;
    din_valid = v;
    clr = c;
    @(posedge clk);
    #1;
    if (err) err_seen++;
    if (locked) lock_seen++;
  endtask

  task automatic send_gen(input logic flip, input logic c);
    logic b;
    gen_next(b);
    send(b ^ flip, 1'b1, c);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    din = 1'b0;
    din_valid = 1'b0;
    clr = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    gen_s = 16'hACE1;
    err_seen = 0;
    lock_seen = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic b;
    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_count", err_count, 32'd0);
    chk("rst_bit_count", bit_count, 32'd0);
    chk("rst_lock_lost", 32'(lock_lost), 32'd0);

    // Clean stream: lock after valid bit 48, then 100 compared bits
    do_reset();
    for (int i = 1; i <= 47; i++) send_gen(1'b0, 1'b0);
    chk("clean_prelock", 32'(locked), 32'd0);
    chk("clean_hunt_state", 32'(state), 32'd1);
    send_gen(1'b0, 1'b0);
    chk("clean_lock", 32'(locked), 32'd1);
    chk("clean_lock_state", 32'(state), 32'd2);
    for (int i = 0; i < 100; i++) send_gen(1'b0, 1'b0);
    chk("clean_err_seen", 32'(err_seen), 32'd0);
    chk("clean_bit_count", bit_count, 32'd100);
    chk("clean_err_count", err_count, 32'd0);

    // Single flipped bit
    send_gen(1'b1, 1'b0);
    chk("single_err_pulse", 32'(err), 32'd1);
    chk("single_err_count", err_count, 32'd1);
    send_gen(1'b0, 1'b0);
    chk("single_err_clear", 32'(err), 32'd0);
    chk("single_locked", 32'(locked), 32'd1);
    chk("single_bit_count", bit_count, 32'd102);
    chk("single_err_seen", 32'(err_seen), 32'd1);

    // Eight errors in one window, eighth coincides with clr (loss sets lock_lost)
    do_reset();
    for (int i = 0; i < 48; i++) send_gen(1'b0, 1'b0);
    for (int i = 0; i < 31; i++) send_gen((i % 4) == 3, 1'b0);
    chk("loss_pre_locked", 32'(locked), 32'd1);
    chk("loss_pre_err_count", err_count, 32'd7);
    send_gen(1'b1, 1'b1);
    chk("loss_locked", 32'(locked), 32'd0);
    chk("loss_state", 32'(state), 32'd1);
    chk("loss_lock_lost", 32'(lock_lost), 32'd1);
    chk("loss_err_pulse", 32'(err), 32'd1);
    chk("loss_clr_err_count", err_count, 32'd0);
    for (int i = 0; i < 31; i++) send_gen(1'b0, 1'b0);
    chk("relock_pre", 32'(locked), 32'd0);
    send_gen(1'b0, 1'b0);
    chk("relock", 32'(locked), 32'd1);
    chk("relock_lost_sticky", 32'(lock_lost), 32'd1);
    send_gen(1'b0, 1'b1);
    chk("clr_lock_lost", 32'(lock_lost), 32'd0);
    chk("clr_bit_count", bit_count, 32'd0);
    chk("clr_keeps_lock", 32'(locked), 32'd1);

    // All-ones input never locks
    do_reset();
    for (int i = 0; i < 200; i++) send(1'b1, 1'b1, 1'b0);
    chk("ones_lock_seen", 32'(lock_seen), 32'd0);
    chk("ones_state", 32'(state), 32'd1);

    // Saturation with CNT_W=4 and clr racing an error
    do_reset();
    for (int i = 0; i < 48; i++) send_gen(1'b0, 1'b0);
    for (int i = 0; i < 200; i++) send_gen((i % 10) == 5, 1'b0);
    chk("sat_err_count4", 32'(err_count4), 32'hF);
    chk("sat_bit_count4", 32'(bit_count4), 32'hF);
    chk("sat_err_count32", err_count, 32'd20);
    chk("sat_bit_count32", bit_count, 32'd200);
    chk("sat_locked4", 32'(locked4), 32'd1);
    send_gen(1'b1, 1'b1);
    chk("sat_clr_err4", 32'(err4), 32'd1);
    chk("sat_clr_err_count4", 32'(err_count4), 32'd0);
    chk("sat_clr_err_count32", err_count, 32'd0);
    send_gen(1'b1, 1'b0);
    chk("sat_after_clr_count4", 32'(err_count4), 32'd1);

    // din_valid toggling: lock point counted in valid bits only
    do_reset();
    for (int k = 1; k <= 48; k++) begin
      send_gen(1'b0, 1'b0);
      if (k == 47) chk("gap_prelock", 32'(locked), 32'd0);
      send(1'b1, 1'b0, 1'b0);
      if (k == 47) chk("gap_prelock_idle", 32'(locked), 32'd0);
      if (k == 48) chk("gap_lock", 32'(locked), 32'd1);
    end
    for (int k = 0; k < 10; k++) begin
      send_gen(1'b0, 1'b0);
      send(1'b1, 1'b0, 1'b0);
    end
    chk("gap_bit_count", bit_count, 32'd10);
    chk("gap_err_seen", 32'(err_seen), 32'd0);
    chk("gap_state", 32'(state), 32'd2);

    // Reset in the middle of lock with an erroneous bit
    rst = 1'b1;
    gen_next(b);
    send(~b, 1'b1, 1'b1);
    rst = 1'b0;
    chk("midrst_err", 32'(err), 32'd0);
    chk("midrst_lock_lost", 32'(lock_lost), 32'd0);
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_locked", 32'(locked), 32'd0);
    chk("midrst_bit_count", bit_count, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prbs16_checker.md
PRBS16_CHECKER -- requirements
Module: prbs16_checker

Interface
REQ-001 Parameter LOCK_CNT, default 32: consecutive correct predictions in HUNT needed to declare lock.
REQ-002 Parameter WIN_LEN, default 64: length of the loss-of-lock window, in valid bits.
REQ-003 Parameter LOSS_ERRS, default 8: errors within one window that force loss of lock.
REQ-004 Parameter CNT_W, default 32: width of err_count and bit_count.
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 din_valid  input  1  qualifies din; when low, all state and counters hold.
REQ-008 din  input  1  received serial PRBS bit.
REQ-009 clr  input  1  synchronous clear of err_count, bit_count and lock_lost.
REQ-010 locked  output  1  high while in LOCKED.
REQ-011 err  output  1  one-cycle pulse per mismatching bit in LOCKED.
REQ-012 err_count  output  CNT_W  saturating total of errors seen in LOCKED.
REQ-013 bit_count  output  CNT_W  saturating total of bits compared in LOCKED.
REQ-014 lock_lost  output  1  sticky flag, set on LOCKED->HUNT transition.
REQ-015 state  output  2  debug: 0=FILL, 1=HUNT, 2=LOCKED.

Function
REQ-016 Sequence definition: the 16-bit history h shifts left with the newest bit entering at h[0]; predicted next bit p = NOT(h[15] XOR h[14] XOR h[12] XOR h[3]). This matches the team's XNOR 16-bit generator (taps 16,15,13,4).
REQ-017 Processing occurs only on cycles with din_valid=1; a bit so qualified is a "valid bit".
REQ-018 FILL: shift din into h; after the 16th valid bit, go to HUNT; the match counter is 0 on entry.
REQ-019 HUNT: compute p from h before the shift, compare with din, then shift din into h.
REQ-020 HUNT match with h != 16'hFFFF: increment the match counter; on reaching LOCK_CNT, go to LOCKED.
REQ-021 HUNT mismatch, or h == 16'hFFFF (the XNOR lock-up state), clears the match counter; the state stays HUNT.
REQ-022 On entry to LOCKED, seed the local generator g with h after the final shift, so the first locked comparison checks the next bit.
REQ-023 LOCKED: g advances once per valid bit by the rule in REQ-016, independent of din. Received errors never corrupt g.
REQ-024 LOCKED comparison: din vs the prediction from g; bit_count increments; on mismatch, err is high the following cycle and err_count increments.
REQ-025 err, locked and state are registered: each is valid the cycle after the valid bit that causes it.
REQ-026 Window: a counter runs 0..WIN_LEN-1 over valid bits in LOCKED; a per-window error count includes the current bit.
REQ-027 Loss of lock: when the window error count reaches LOSS_ERRS, go to HUNT with the match counter at 0, keep h, and set lock_lost.
REQ-028 Window wrap: on the bit completing the window, evaluate the loss check first, then reset both window counters to 0.
REQ-029 Window counters reset to 0 on every entry to LOCKED.
REQ-030 err_count and bit_count saturate at all-ones and never wrap.
REQ-031 clr has priority over a simultaneous increment: the counters read 0 next cycle, and the coincident error is not counted.
REQ-032 clr also clears lock_lost, but if loss of lock occurs on the same cycle, lock_lost is set (set wins).
REQ-033 A coincident err pulse is still issued when clr is asserted.
REQ-034 clr does not affect state, h, g or the window counters.

Reset
REQ-035 On rst, the following take effect the next cycle: state=FILL; h, g and all counters =0; locked=err=lock_lost=0; err_count=bit_count=0.
REQ-036 rst takes priority over din_valid and clr.
REQ-037 rst asserted mid-lock abandons the lock with no err pulse, and lock_lost is not set.

Verification
REQ-038 Clean stream from the XNOR generator seeded 16'hACE1, continuous valid -> locked rises the cycle after valid bit 48 (16 FILL + 32 HUNT); err stays 0; bit_count=100 after 100 further bits.
REQ-039 Locked, a single flipped bit -> exactly one err pulse; err_count=1; locked stays 1.
REQ-040 Locked, 8 flipped bits within one 64-bit window -> locked falls after the 8th error; lock_lost=1, state=1; clean data relocks after 32 more bits.
REQ-041 200 valid bits of all-ones after reset -> locked never asserts; state stays 1 after FILL.
REQ-042 CNT_W=4, locked, 20 isolated errors spread across windows -> err_count holds 4'hF; clr asserted with an error -> err_count=0 next cycle and err pulses once.
REQ-043 din_valid toggled 1-0 throughout a clean stream -> same lock point counted in valid bits; no counter moves on invalid cycles.
